// File: rtl/lock_pkg.sv
// Shared types and constants for the electronic-lock code transmitter.
package lock_pkg;

    localparam int CODE_W_DEF = 5;
    localparam logic [CODE_W_DEF-1:0] LOCK_CODE = 5'b01011;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        SHIFT,
        WAIT_ACK,
        LOCKOUT
    } lock_tx_state_e;

endpackage

// File: rtl/lock_bit_timer.sv
// Bit-period down-counter: bit_tick marks the last clock of every BIT_DIV-clock period.
module lock_bit_timer #(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    output logic bit_tick
);

    localparam int TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (load || bit_tick) cnt_d = TW'(BIT_DIV - 1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lock_code_tx.sv
// Serial code transmitter: guard gap, MSB-first code, bounded unlock wait, failure lockout.
module lock_code_tx
    import lock_pkg::*;
#(
    parameter int CODE_W         = CODE_W_DEF,
    parameter int BIT_DIV        = 1,
    parameter int GAP_BITS       = 2,
    parameter int ACK_TIMEOUT    = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [CODE_W-1:0]               code_i,
    input  logic                            code_valid,
    output logic                            code_ready,
    output logic                            ser_out,
    output logic                            ser_active,
    input  logic                            unlock_i,
    output logic                            done,
    output logic                            pass,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic                            locked_out
);

    localparam int BC_W = $clog2(((CODE_W > GAP_BITS) ? CODE_W : GAP_BITS) + 1);
    localparam int AC_W = $clog2(ACK_TIMEOUT + 1);
    localparam int LC_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FC_W = $clog2(MAX_FAIL + 1);

    lock_tx_state_e    state_q, state_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [AC_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [FC_W-1:0]   fail_q, fail_d, fail_inc;
    logic              ser_q, ser_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              locked_q, locked_d;
    logic              tmr_load, bit_tick;

    lock_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .bit_tick (bit_tick)
    );

    // Blocking ready during the done cycle keeps the next accept at least one cycle after done.
    assign code_ready = (state_q == IDLE) && !done_q;
    assign ser_active = (state_q == GAP) || (state_q == SHIFT);
    assign ser_out    = ser_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_cnt   = fail_q;
    assign locked_out = locked_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        ack_cnt_d  = ack_cnt_q;
        lock_cnt_d = lock_cnt_q;
        fail_d     = fail_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        tmr_load   = 1'b0;
        fail_inc   = (fail_q == FC_W'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (code_valid && code_ready) begin
                    shift_d   = code_i;
                    bit_cnt_d = '0;
                    tmr_load  = 1'b1;
                    state_d   = (GAP_BITS == 0) ? SHIFT : GAP;
                end
            end
            GAP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == BC_W'(GAP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = SHIFT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt_q == BC_W'(CODE_W - 1)) begin
                        ack_cnt_d = '0;
                        state_d   = WAIT_ACK;
                    end else begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (unlock_i) begin
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    fail_d  = '0;
                    state_d = IDLE;
                end else if (ack_cnt_q == AC_W'(ACK_TIMEOUT - 1)) begin
                    done_d = 1'b1;
                    pass_d = 1'b0;
                    fail_d = fail_inc;
                    if (fail_inc == FC_W'(MAX_FAIL)) begin
                        lock_cnt_d = '0;
                        state_d    = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == LC_W'(LOCKOUT_CYCLES - 1)) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Serial line and lockout flag are registered versions of the next state's outputs.
        ser_d    = (state_d == SHIFT) ? shift_d[CODE_W-1] : 1'b0;
        locked_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            ack_cnt_q  <= '0;
            lock_cnt_q <= '0;
            fail_q     <= '0;
            ser_q      <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ack_cnt_q  <= ack_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            fail_q     <= fail_d;
            ser_q      <= ser_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            locked_q   <= locked_d;
        end
    end

endmodule

// File: doc/lock_code_tx.md
# lock_code_tx

Bit-serial code transmitter for the electronic lock. It accepts a parallel entry code over a valid/ready handshake and drives it MSB-first onto the lock's serial input, preceded by a zero guard gap. It then waits a bounded window for the lock's unlock indication and reports pass or fail. It counts consecutive failures and enforces a timed lockout after too many. It sits between the keypad/controller logic and the serial lock detector.

## Interface
- CODE_W, 5: code length in bits.
- BIT_DIV, 1: clocks per serial bit; must be ≥1.
- GAP_BITS, 2: zero bits driven before each code.
- ACK_TIMEOUT, 8: WAIT_ACK cycles allowed for unlock; must be ≥1.
- MAX_FAIL, 3: consecutive failures that trigger lockout; must be ≥1.
- LOCKOUT_CYCLES, 64: lockout duration in clocks.

- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- code_i  in  CODE_W  code to send; sampled on accept.
- code_valid  in  1  code_i is valid.
- code_ready  out  1  block can accept a code.
- ser_out  out  1  serial line to the lock; registered; idle level 0.
- ser_active  out  1  high during GAP and SHIFT.
- unlock_i  in  1  unlock indication from the lock.
- done  out  1  one-cycle pulse when an attempt resolves.
- pass  out  1  result of the last attempt; valid from done and held until the next done.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive-failure count.
- locked_out  out  1  high while in LOCKOUT.

## Operation
- States: IDLE, GAP, SHIFT, WAIT_ACK, LOCKOUT.
- Reset values: state IDLE, ser_out 0, ser_active 0, done 0, pass 0, fail_cnt 0, locked_out 0. code_ready is 1 from the first cycle after reset.
- IDLE
  - code_ready = 1.
  - Accept on the edge where code_valid && code_ready.
  - On accept: load code_i into the shift register, clear the bit timer, go to GAP.
- GAP
  - ser_out = 0 for GAP_BITS bit periods, then go to SHIFT.
  - If GAP_BITS = 0, go directly to SHIFT.
- SHIFT
  - Drive ser_out with code bits MSB first, each held BIT_DIV clocks.
  - After CODE_W bits, go to WAIT_ACK.
- WAIT_ACK
  - ser_out = 0; a cycle counter runs.
  - If unlock_i = 1 on any edge within ACK_TIMEOUT edges:
    - done = 1 and pass = 1 next cycle; fail_cnt cleared; go to IDLE.
  - On timeout without unlock:
    - done = 1 and pass = 0; fail_cnt incremented.
    - If the new count equals MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- LOCKOUT
  - locked_out = 1, code_ready = 0.
  - After LOCKOUT_CYCLES clocks: clear fail_cnt, drop locked_out, go to IDLE.
- unlock_i is ignored in IDLE, GAP, SHIFT and LOCKOUT.
- code_ready = 0 in every state except IDLE. code_valid outside IDLE is ignored; there is no queueing.
- fail_cnt saturates at MAX_FAIL.
- Reset asserted mid-attempt: next edge returns to IDLE with all outputs at their reset values. The frame is abandoned and no done pulse is produced.

## Timing
- Let E0 be the accept edge.
- Defaults (BIT_DIV = 1, GAP_BITS = 2):
  - ser_out = 0 in cycles E0+1 and E0+2.
  - Code bits [4]..[0] in cycles E0+3..E0+7.
  - WAIT_ACK starts at cycle E0+8.
- General case: first code bit at E0 + 1 + GAP_BITS·BIT_DIV. Frame length is (GAP_BITS + CODE_W)·BIT_DIV cycles.
- unlock_i seen at WAIT_ACK edge k (k = 1..ACK_TIMEOUT): done is high in the following cycle.
- Timeout: done is high in the cycle after edge ACK_TIMEOUT.
- Lockout entry: locked_out rises in the same cycle as the failing done pulse.
- Lockout exit: code_ready returns LOCKOUT_CYCLES cycles after locked_out rises.
- Back-to-back attempts: earliest next accept is the cycle after done.

## Structure
- Package lock_pkg holds:
  - the lock_tx_state_e enum;
  - the default code constant LOCK_CODE = 5'b01011;
  - the default CODE_W.
- Sub-module lock_bit_timer: bit-period down-counter that generates bit_tick every BIT_DIV clocks, restartable by a load strobe. Used for both GAP and SHIFT.
- The WAIT_ACK and LOCKOUT counters stay in the top module.

## Test plan
- Reset, then present code_i = 5'b01011 with valid. Expect:
  - ser_out sequence 0,0,0,1,0,1,1 over cycles E0+1..E0+7;
  - unlock_i driven high at WAIT_ACK edge 2 gives done with pass = 1 at E0+10 and fail_cnt = 0.
- Send 5'b10101 with unlock_i held low. Expect done with pass = 0 at the cycle after the 8th WAIT_ACK edge, and fail_cnt = 1.
- Three consecutive failures. Expect:
  - locked_out = 1 and code_ready = 0 for 64 cycles;
  - then fail_cnt = 0 and code_ready = 1.
- BIT_DIV = 3. Expect each code bit held exactly 3 cycles and the frame lasting 21 cycles.
- Assert rstn = 0 mid-SHIFT. Expect the next edge to give ser_out = 0, state IDLE and no done pulse.
- Drive unlock_i = 1 during GAP/SHIFT only, then low in WAIT_ACK. Expect pass = 0 (the early unlock is ignored).
